// File: rtl/response_framer_if.sv
// Outbound message channel from the response framer to the encoder.
// The framer drives word/valid/last and the encoder drives ready.
interface response_framer_if;
  logic [31:0] msg_data;
  logic        msg_valid;
  logic        msg_last;
  logic        msg_ready;

  modport master (output msg_data, output msg_valid, output msg_last, input msg_ready);
  modport slave  (input msg_data, input msg_valid, input msg_last, output msg_ready);
endinterface

// File: rtl/response_framer.sv
// Captures a command unit's parameter stream and emits it as a framed message.
// Define RESPONSE_FRAMER_TIMESTAMP_EN to insert a systime STAMP word after the header.
module response_framer #(
  parameter int NUNITS     = 4,
  parameter int MAX_PARAMS = 8,
  parameter int RSP_BITS   = 8,
  localparam int UW = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          systime,
  input  logic                 cmd_start,
  input  logic [UW-1:0]        cmd_unit,
  output logic                 rsp_busy,
  input  logic [32*NUNITS-1:0] unit_param_data,
  input  logic [NUNITS-1:0]    unit_param_write,
  input  logic [NUNITS-1:0]    unit_cmd_done,
  input  logic [NUNITS-1:0]    invol_req,
  output logic [NUNITS-1:0]    invol_grant,
  response_framer_if.master    msg,
  output logic                 overflow
);
  localparam int AW = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;
  localparam int CW = $clog2(MAX_PARAMS + 1);

`ifdef RESPONSE_FRAMER_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CAPTURE, HEADER, STAMP, PAYLOAD} state_t;

  state_t              state_reg, state_next;
  logic [UW-1:0]       owner_reg, last_grant_reg, grant_idx;
  logic                invol_reg, frame_ovf_reg, overflow_reg;
  logic [CW-1:0]       count_reg, rd_cnt_reg, rd_cnt_next;
  logic [RSP_BITS-1:0] rsp_id_reg;
  logic [NUNITS-1:0]   invol_grant_reg, grant_next;
  logic [31:0]         mem [MAX_PARAMS];
  logic [31:0]         rd_data_reg, header, stamp_word;
  logic [31:0]         unit_data [NUNITS];
  logic [31:0]         own_data;
  logic                own_write, own_done, req_any, is_last, mem_we;

  for (genvar gi = 0; gi < NUNITS; gi++) begin : g_unpack
    assign unit_data[gi] = unit_param_data[32*gi +: 32];
  end

  assign own_data  = unit_data[owner_reg];
  assign own_write = unit_param_write[owner_reg];
  assign own_done  = unit_cmd_done[owner_reg];
  assign req_any   = |invol_req;
  assign is_last   = (rd_cnt_reg == count_reg - CW'(1));
  assign mem_we    = (state_reg == CAPTURE) && own_write && !own_done &&
                     (count_reg < CW'(MAX_PARAMS));

  // Round robin: scanning downward lets the unit nearest after the last grant win.
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = last_grant_reg;
    for (int i = NUNITS; i >= 1; i--) begin
      idx = (int'(last_grant_reg) + i) % NUNITS;
      if (invol_req[idx]) grant_idx = UW'(idx);
    end
  end

`ifdef RESPONSE_FRAMER_TIMESTAMP_EN
  logic [31:0] stamp_reg;
  always_ff @(posedge clk) begin
    if (reset) stamp_reg <= '0;
    else if (state_reg == CAPTURE && own_done) stamp_reg <= systime;
  end
  assign stamp_word = stamp_reg;
`else
  logic unused_systime;
  assign unused_systime = ^systime;
  assign stamp_word     = '0;
`endif

  always_comb begin
    header              = '0;
    header[31:24]       = 8'(count_reg);
    header[23]          = invol_reg;
    header[22]          = frame_ovf_reg;
    header[21]          = TS_EN;
    header[RSP_BITS-1:0] = rsp_id_reg;
  end

  always_comb begin
    state_next    = state_reg;
    rd_cnt_next   = '0;
    grant_next    = '0;
    msg.msg_valid = 1'b0;
    msg.msg_last  = 1'b0;
    msg.msg_data  = '0;
    case (state_reg)
      IDLE: begin
        if (cmd_start) begin
          state_next = CAPTURE;
        end else if (req_any) begin
          state_next = CAPTURE;
          grant_next = NUNITS'(1) << grant_idx;
        end
      end
      CAPTURE: begin
        if (own_done) state_next = (count_reg == '0) ? IDLE : HEADER;
      end
      HEADER: begin
        msg.msg_valid = 1'b1;
        msg.msg_data  = header;
        if (msg.msg_ready) state_next = TS_EN ? STAMP : PAYLOAD;
      end
      STAMP: begin
        msg.msg_valid = 1'b1;
        msg.msg_data  = stamp_word;
        if (msg.msg_ready) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        msg.msg_valid = 1'b1;
        msg.msg_data  = rd_data_reg;
        msg.msg_last  = is_last;
        rd_cnt_next   = rd_cnt_reg;
        if (msg.msg_ready) begin
          rd_cnt_next = is_last ? '0 : rd_cnt_reg + CW'(1);
          if (is_last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      last_grant_reg  <= UW'(NUNITS - 1);
      invol_reg       <= 1'b0;
      frame_ovf_reg   <= 1'b0;
      overflow_reg    <= 1'b0;
      count_reg       <= '0;
      rd_cnt_reg      <= '0;
      rsp_id_reg      <= '0;
      invol_grant_reg <= '0;
    end else begin
      state_reg       <= state_next;
      rd_cnt_reg      <= rd_cnt_next;
      invol_grant_reg <= grant_next;
      case (state_reg)
        IDLE: begin
          if (cmd_start || req_any) begin
            count_reg     <= '0;
            frame_ovf_reg <= 1'b0;
            rsp_id_reg    <= '0;
            invol_reg     <= !cmd_start;
            owner_reg     <= cmd_start ? cmd_unit : grant_idx;
          end
          if (!cmd_start && req_any) last_grant_reg <= grant_idx;
        end
        CAPTURE: begin
          // A write coinciding with done is a protocol error: the word is dropped.
          if (own_done) begin
            if (!own_write) rsp_id_reg <= own_data[RSP_BITS-1:0];
          end else if (own_write) begin
            if (count_reg == CW'(MAX_PARAMS)) begin
              overflow_reg  <= 1'b1;
              frame_ovf_reg <= 1'b1;
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end
        end
        PAYLOAD: if (msg.msg_ready && is_last) count_reg <= '0;
        default: ;
      endcase
    end
  end

  // Registered read, addressed by the next read pointer so data lines up with PAYLOAD.
  always_ff @(posedge clk) begin
    if (mem_we) mem[count_reg[AW-1:0]] <= own_data;
    rd_data_reg <= mem[rd_cnt_next[AW-1:0]];
  end

  assign rsp_busy    = (state_reg != IDLE);
  assign invol_grant = invol_grant_reg;
  assign overflow    = overflow_reg;
endmodule
